// File: rtl/rs_16_8_pkg.sv
// ============================================================================
// Module  : rs_16_8_pkg
// Brief   : Shared RS(16,8) code parameters, symbol type and framer out-state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_16_8_pkg;

    localparam int RS_N     = 16;
    localparam int RS_K     = 8;
    localparam int RS_SYM_W = 8;

    typedef logic [RS_SYM_W-1:0] sym_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_e;

endpackage

`default_nettype wire

// File: rtl/rs_frame_buf.sv
// ============================================================================
// Module  : rs_frame_buf
// Brief   : NFRM-slot frame store of K symbols each, one write port, registered
//           read port, slot pointers and occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_frame_buf
    import rs_16_8_pkg::*;
#(
    parameter int K     = RS_K,
    parameter int SYM_W = RS_SYM_W,
    parameter int NFRM  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(K)-1:0]        wr_off,
    input  logic [SYM_W-1:0]            wr_data,
    input  logic                        commit,
    input  logic                        rel,
    input  logic [$clog2(K)-1:0]        rd_off,
    output logic [SYM_W-1:0]            rd_data,
    output logic [$clog2(NFRM):0]       occ
);

    localparam int OFF_W  = $clog2(K);
    localparam int SLOT_W = $clog2(NFRM);
    localparam int OCC_W  = SLOT_W + 1;
    localparam int DEPTH  = NFRM * K;

    logic [SYM_W-1:0]  mem [DEPTH];
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [SYM_W-1:0]  rd_data_q;

    // Pointers wrap naturally because NFRM and K are powers of two.
    always_comb begin
        wr_slot_d = wr_slot_q + SLOT_W'(commit);
        rd_slot_d = rd_slot_q + SLOT_W'(rel);
        occ_d     = occ_q + OCC_W'(commit) - OCC_W'(rel);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_slot_q, wr_off}] <= wr_data;
        end
    end

    // The read address looks one beat ahead so the registered data lines up
    // with the beat that will be presented after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            occ_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            occ_q     <= occ_d;
            rd_data_q <= mem[{rd_slot_d, rd_off}];
        end
    end

    assign rd_data = rd_data_q;
    assign occ     = occ_q;

endmodule

`default_nettype wire

// File: rtl/rs_dec_info_framer.sv
// ============================================================================
// Module  : rs_dec_info_framer
// Brief   : Keeps the info symbols of decoded RS codewords, buffers whole frames
//           and replays them as a val/sop/eop stream with ready backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_dec_info_framer
    import rs_16_8_pkg::*;
#(
    parameter int N     = RS_N,
    parameter int K     = RS_K,
    parameter int SYM_W = RS_SYM_W,
    parameter int NFRM  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             symb_out_val,
    input  logic [7:0]       symb_out_cnt,
    input  logic [SYM_W-1:0] symb_corrected,
    input  logic             dout_rdy,
    output logic             dout_val,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic [SYM_W-1:0] dout,
    output logic             ovf,
    output logic             seq_err,
    output logic [15:0]      drop_cnt
);

    localparam int CNT_W = 8;
    localparam int EXP_W = $clog2(N);
    localparam int OFF_W = $clog2(K);
    localparam int OCC_W = $clog2(NFRM) + 1;

    localparam logic [CNT_W-1:0] C_K        = CNT_W'(K);
    localparam logic [CNT_W-1:0] C_K_LAST   = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] C_N_LAST   = CNT_W'(N - 1);
    localparam logic [OFF_W-1:0] C_OFF_LAST = OFF_W'(K - 1);
    localparam logic [OCC_W-1:0] C_FULL     = OCC_W'(NFRM);

    // Input sequence tracking
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sync_q, sync_d;     // 0 while waiting for cnt==0 after an error
    logic             keep_q, keep_d;     // current frame owns a buffer slot
    logic             ovf_q, ovf_d;
    logic             seq_err_q, seq_err_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             in_seq, is_first, keep_now;
    logic             wr_en, commit;
    logic [1:0]       ndrop;
    logic [16:0]      drop_sum;

    // Output side
    out_state_e       state_q, state_d;
    logic [OFF_W-1:0] rd_off_q, rd_off_d;
    logic             hs, rel;
    logic [SYM_W-1:0] rd_data;
    logic [OCC_W-1:0] occ;

    rs_frame_buf #(
        .K     (K),
        .SYM_W (SYM_W),
        .NFRM  (NFRM)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_off  (symb_out_cnt[OFF_W-1:0]),
        .wr_data (symb_corrected),
        .commit  (commit),
        .rel     (rel),
        .rd_off  (rd_off_d),
        .rd_data (rd_data),
        .occ     (occ)
    );

    always_comb begin
        exp_d     = exp_q;
        sync_d    = sync_q;
        keep_d    = keep_q;
        seq_err_d = 1'b0;
        ovf_d     = 1'b0;
        wr_en     = 1'b0;
        commit    = 1'b0;
        in_seq    = 1'b0;
        is_first  = 1'b0;
        keep_now  = keep_q;
        if (symb_out_val) begin
            in_seq   = sync_q && (symb_out_cnt == CNT_W'(exp_q));
            is_first = (symb_out_cnt == '0);
            if (sync_q && !in_seq) begin
                seq_err_d = 1'b1;
                sync_d    = 1'b0;
                keep_d    = 1'b0;
                exp_d     = '0;
            end
            // cnt==0 always (re)starts a frame, even right after an error.
            if (in_seq || is_first) begin
                sync_d = 1'b1;
                exp_d  = (symb_out_cnt == C_N_LAST) ? '0
                                                     : EXP_W'(symb_out_cnt) + EXP_W'(1);
                if (is_first) begin
                    keep_now = (occ != C_FULL);
                    keep_d   = keep_now;
                    ovf_d    = !keep_now;
                end
                if (keep_now && (symb_out_cnt < C_K)) begin
                    wr_en  = 1'b1;
                    commit = (symb_out_cnt == C_K_LAST);
                end
            end
        end
        ndrop      = {1'b0, seq_err_d} + {1'b0, ovf_d};
        drop_sum   = {1'b0, drop_cnt_q} + {15'b0, ndrop};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q      <= '0;
            sync_q     <= 1'b1;
            keep_q     <= 1'b0;
            ovf_q      <= 1'b0;
            seq_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            exp_q      <= exp_d;
            sync_q     <= sync_d;
            keep_q     <= keep_d;
            ovf_q      <= ovf_d;
            seq_err_q  <= seq_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Output FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_off_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_off_q <= rd_off_d;
        end
    end

    // Output FSM: next state and beat offset
    always_comb begin
        hs       = dout_val && dout_rdy;
        rel      = hs && (rd_off_q == C_OFF_LAST);
        rd_off_d = rd_off_q;
        if (hs) begin
            rd_off_d = rel ? '0 : rd_off_q + OFF_W'(1);
        end
        state_d = state_q;
        case (state_q)
            IDLE:    if (occ != '0) state_d = SEND;
            SEND:    if (rel && (occ == OCC_W'(1)) && !commit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output FSM: outputs. A committed frame is presented as soon as occ rises,
    // so the first sop does not wait for the IDLE->SEND transition.
    always_comb begin
        dout_val = (state_q == SEND) || (occ != '0);
        dout_sop = dout_val && (rd_off_q == '0);
        dout_eop = dout_val && (rd_off_q == C_OFF_LAST);
        dout     = dout_val ? rd_data : '0;
    end

    assign ovf      = ovf_q;
    assign seq_err  = seq_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire
